bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display driver. It accepts a 14-bit unsigned binary value over a valid/ready handshake. It converts the value with a one-bit-per-cycle double-dabble engine and holds the resulting 16-bit packed BCD word stable on `bcd`, which drives the display driver's `number` input. A single-cycle `done` pulse marks each update.

## Interface
- `BIN_W`, 14: binary input width; fixed to 14, which covers 0–16383.
- `DIGITS`, 4: BCD digits presented on `bcd`; fixed to 4.
- `clk`  in  1  system clock, all logic rising-edge.
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  `bin` is valid this cycle.
- `in_ready`  out  1  block can accept a value; high only in IDLE.
- `bin`  in  14  unsigned binary value to convert.
- `bcd`  out  16  packed BCD result, digit 3 in [15:12] down to digit 0 in [3:0]. Registered and held between conversions.
- `done`  out  1  one-cycle pulse: `bcd` was updated this cycle.
- `overflow`  out  1  registered with `bcd`: last input exceeded 9999.

## Operation
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `bin` into the shift register, clear the 20-bit scratch (5 BCD digits), set the iteration counter to 0, and go to SHIFT.
  - SHIFT: one iteration per cycle, 14 iterations.
    - For each of the 5 scratch digits, add 3 if the digit is ≥5.
    - Shift {scratch, shift register} left by 1.
    - After iteration 13 (counter == BIN_W-1), go to LOAD.
  - LOAD: write the result to `bcd` and `overflow`, pulse `done`=1, return to IDLE.
- Result rules:
  - The scratch is 5 digits, so the full conversion of 0–16383 is exact.
  - `overflow` = (ten-thousands digit ≠ 0) OR (low 4 digits > 9999 is impossible, so ignore that case). In practice `overflow` = ten-thousands digit ≠ 0, i.e. `bin` > 9999 ⇔ `bin` ≥ 10000.
  - The value written to `bcd` on overflow depends on configuration (see Configuration).
- `in_valid` and `bin` are ignored outside IDLE; there is no queueing.
- `bcd` and `overflow` change only in LOAD or on reset.

## Timing
- Reset values: `bcd`=16'h0000, `done`=0, `overflow`=0, FSM=IDLE, so `in_ready`=1 (combinational from state, including while reset is asserted).
- Latency: handshake at edge E0; SHIFT iterations at edges E1..E14; LOAD entered after E14; `bcd` and `done` are updated at edge E15.
  - `done` is high for the cycle following E15.
  - `in_ready` rises in that same cycle.
- Throughput: one conversion per 16 cycles. With `in_valid` held high, the next value is accepted in the cycle in which `done` is high.
- Reset mid-conversion: the conversion is aborted immediately. `bcd` returns to 0, and no `done` is produced for the aborted value.

## Configuration
- `BIN2BCD_SATURATE_EN`
  - Defined: when `bin` > 9999, `bcd` = 16'h9999 and `overflow`=1.
  - Undefined: `bcd` = low 4 digits of the exact result (value mod 10000); `overflow` is still computed and reported.
  - Input ≤ 9999: behaviour is identical in both builds.

## Structure
- Shared package `bcd_pkg`:
  - `BIN_W`=14, `DIGITS`=4, `SCRATCH_DIGITS`=5, `BCD_MAX`=16'h9999.
  - FSM state enum {IDLE, SHIFT, LOAD}.
  - Iteration counter width: $clog2(BIN_W).
- Sub-module `bcd_digit_adjust`: 4-bit combinational add-3-if-≥5, instantiated 5 times inside the SHIFT datapath.

## Test plan
- `bin`=0 → `done` at cycle 16 after the handshake; `bcd`=16'h0000, `overflow`=0.
- `bin`=1234 → `in_ready` low for 15 cycles; exactly one `done` pulse; `bcd`=16'h1234.
- `bin`=9999 → `bcd`=16'h9999, `overflow`=0. Then `bin`=10000 → `overflow`=1, and `bcd`=16'h9999 with the macro, 16'h0000 without it.
- `bin`=12345 → `overflow`=1; `bcd`=16'h9999 with the macro, 16'h2345 without it.
- `in_valid` held high with 42 then 7 → second value accepted in the `done` cycle. `bcd` holds 16'h0042 until the second `done`, then shows 16'h0007.
- `reset_n` pulsed low during iteration 7 of 1234 → `bcd`=0, `done` never pulses, `in_ready`=1. Then `bin`=56 → `bcd`=16'h0056.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
package bcd_pkg;
  localparam int BIN_W          = 14;
  localparam int DIGITS         = 4;
  localparam int SCRATCH_DIGITS = 5;
  localparam int CNT_W          = $clog2(BIN_W);
  localparam logic [4*DIGITS-1:0] BCD_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;
endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 when a BCD digit is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one double-dabble bit per cycle.
// Optional BIN2BCD_SATURATE_EN: values above 9999 show 16'h9999 instead of value mod 10000.
module bin_to_bcd_seq
  import bcd_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done,
  output logic                  overflow
);
  localparam int SCR_W = 4*SCRATCH_DIGITS;

  state_e                 state_q, state_d;
  logic [BIN_W-1:0]       sh_q, sh_d;
  logic [SCR_W-1:0]       scr_q, scr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [SCRATCH_DIGITS-1:0][3:0] scr_dig, adj_dig;
  logic [SCR_W+BIN_W-1:0]         shifted;
  logic                           ovf_w;
  logic [4*DIGITS-1:0]            res_w;

  assign scr_dig = scr_q;

  for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (.din(scr_dig[g]), .dout(adj_dig[g]));
  end

  assign shifted = {adj_dig, sh_q} << 1;
  // Only the ten-thousands digit can make the result exceed four digits.
  assign ovf_w   = scr_q[SCR_W-1 -: 4] != 4'd0;

`ifdef BIN2BCD_SATURATE_EN
  assign res_w = ovf_w ? BCD_MAX : scr_q[4*DIGITS-1:0];
`else
  assign res_w = scr_q[4*DIGITS-1:0];
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted[SCR_W+BIN_W-1:BIN_W];
        sh_d  = shifted[BIN_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W-1)) state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = res_w;
        ovf_d   = ovf_w;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign bcd      = bcd_q;
  assign done     = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and random checks of bin_to_bcd_seq against an arithmetic decimal model.
module tb_bin_to_bcd_seq;
`ifdef BIN2BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] bin = '0;
  logic [15:0] bcd;
  logic        done;
  logic        overflow;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .bcd(bcd), .done(done), .overflow(overflow)
  );

  function automatic logic [15:0] model_bcd(input int v);
    int m;
    if (SAT && v > 9999) return 16'h9999;
    m = v % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents v, waits for the handshake, then watches until done.
  task automatic convert(input int v, input logic [15:0] prev_bcd);
    int k;
    int rdy_low;
    int dones;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    bin = 14'(v);
    k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    chk("accept_timeout", 32'(k < 40), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    bin = 14'($urandom_range(0, 16383));
    rdy_low = 0; dones = 0; lat = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (lat == 0) begin
          lat = i;
          chk("bcd", 32'(bcd), 32'(model_bcd(v)));
          chk("ovf", 32'(overflow), 32'(v > 9999));
          chk("ready_at_done", 32'(in_ready), 32'd1);
        end
      end else if (lat == 0) begin
        if (!in_ready) rdy_low++;
        if (bcd !== prev_bcd) chk("bcd_hold", 32'(bcd), 32'(prev_bcd));
      end
    end
    chk("latency", 32'(lat), 32'd16);
    chk("ready_low", 32'(rdy_low), 32'd15);
    chk("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    logic [15:0] last;
    int k;
    int dones;
    // reset state, including while asserted
    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    convert(0, 16'h0000);
    convert(1234, 16'h0000);
    convert(9999, 16'h1234);
    convert(10000, 16'h9999);
    convert(12345, model_bcd(10000));
    convert(16383, model_bcd(12345));
    last = model_bcd(16383);

    // back-to-back with in_valid held high: 42 then 7
    @(negedge clk);
    in_valid = 1'b1; bin = 14'd42;
    @(posedge clk);
    #1 bin = 14'd7;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (!done && bcd !== last) chk("b2b_hold0", 32'(bcd), 32'(last));
    end while (!done && k < 40);
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_bcd42", 32'(bcd), 32'h0042);
    chk("b2b_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepted", 32'(in_ready), 32'd0);
    k = 0;
    while (!done && k < 40) begin
      if (bcd !== 16'h0042) chk("b2b_hold42", 32'(bcd), 32'h0042);
      @(negedge clk); k++;
    end
    chk("b2b_second_done", 32'(done), 32'd1);
    chk("b2b_bcd7", 32'(bcd), 32'h0007);

    // reset during iteration 7 of 1234
    @(negedge clk);
    in_valid = 1'b1; bin = 14'd1234;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    dones = 0;
    repeat (30) begin @(negedge clk); if (done) dones++; end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_bcd_after", 32'(bcd), 32'h0);
    convert(56, 16'h0000);
    last = 16'h0056;

    // random values
    for (int i = 0; i < 24; i++) begin
      int v;
      v = (i < 4) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
      convert(v, last);
      last = model_bcd(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
